// File: rtl/systolic_out_reader_if.sv
// ---------------------------------------------------------------------------
// systolic_out_reader_if
// Valid/ready beat stream from the output-buffer reader toward the
// post-processing / requantization stage.
//   m_data     : one beat of a buffer row (beat 0 = least significant columns)
//   m_valid    : beat present; never withdrawn before its handshake
//   m_ready    : consumer accepts the beat when high together with m_valid
//   m_row_last : final beat of a buffer row
//   m_last     : final beat of the whole drain
// Modports: master = reader side, slave = consumer side.
// ---------------------------------------------------------------------------
interface systolic_out_reader_if #(
    parameter int BEAT_WIDTH = 256
);
    logic [BEAT_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_row_last;
    logic                  m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_row_last,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_row_last,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/systolic_out_reader.sv
// ---------------------------------------------------------------------------
// systolic_out_reader
// Drains rows 0..num_rows-1 of the registered-read systolic output buffer and
// sends each row as BEATS beats of BEAT_WIDTH bits over a valid/ready stream.
// Ports:
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   start, num_rows    : drain request and row count (sampled in IDLE only)
//   rd_addr_outbuffer  : registered read address into the output buffer
//   rd_data_outbuffer  : buffer row, valid one cycle after its address
//   strm (master)      : m_data / m_valid / m_ready / m_row_last / m_last
//   busy               : drain in progress
//   done               : one-cycle pulse after the final handshake
//   error              : one-cycle pulse for start with an illegal num_rows
// ---------------------------------------------------------------------------
module systolic_out_reader #(
    parameter int DATAWIDTH_output = 32,
    parameter int N_SIZE           = 32,
    parameter int ADDR_WIDTH       = 10,
    parameter int DEPTH            = 543,
    parameter int BEAT_WIDTH       = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [ADDR_WIDTH-1:0]                num_rows,
    output logic [ADDR_WIDTH-1:0]                rd_addr_outbuffer,
    input  logic [N_SIZE*DATAWIDTH_output-1:0]   rd_data_outbuffer,
    systolic_out_reader_if.master                strm,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error
);

    localparam int ROW_WIDTH = N_SIZE * DATAWIDTH_output;
    localparam int BEATS     = ROW_WIDTH / BEAT_WIDTH;
    localparam int BI_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BI_W-1:0]       LAST_BEAT = BI_W'(BEATS - 1);
    localparam logic [BI_W-1:0]       BEAT_ONE  = BI_W'(1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        STREAM  = 2'd3
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   row_cnt_r;
    logic [ADDR_WIDTH-1:0]   rows_q_r;
    logic [BI_W-1:0]         beat_r;
    logic [ROW_WIDTH-1:0]    row_reg_r;
    logic [ADDR_WIDTH-1:0]   rd_addr_r;
    logic [BEAT_WIDTH-1:0]   m_data_r;
    logic                    m_valid_r;
    logic                    m_row_last_r;
    logic                    m_last_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    error_r;

    logic                    last_row_s;
    logic [BI_W-1:0]         beat_nxt_s;
    logic                    start_legal_s;

    // Selects beat idx of a row; beat 0 holds the lowest columns.
    function automatic logic [BEAT_WIDTH-1:0] beat_slice(
        input logic [ROW_WIDTH-1:0] row,
        input logic [BI_W-1:0]      idx
    );
        logic [BEAT_WIDTH-1:0] sel;
        sel = '0;
        for (int i = 0; i < BEATS; i++) begin
            sel = (idx == BI_W'(i)) ? row[i*BEAT_WIDTH +: BEAT_WIDTH] : sel;
        end
        return sel;
    endfunction

    assign last_row_s    = (row_cnt_r == (rows_q_r - ADDR_ONE));
    assign beat_nxt_s    = beat_r + BEAT_ONE;
    assign start_legal_s = (num_rows != ADDR_ZERO) && (num_rows <= DEPTH_A);

    // Drain FSM; every output is driven from a register updated here so the
    // stream is stable while stalled and zero whenever m_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            row_cnt_r    <= '0;
            rows_q_r     <= '0;
            beat_r       <= '0;
            row_reg_r    <= '0;
            rd_addr_r    <= '0;
            m_data_r     <= '0;
            m_valid_r    <= 1'b0;
            m_row_last_r <= 1'b0;
            m_last_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && start_legal_s) begin
                        rows_q_r  <= num_rows;
                        row_cnt_r <= '0;
                        rd_addr_r <= '0;
                        busy_r    <= 1'b1;
                        state_r   <= ISSUE;
                    end else if (start) begin
                        error_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    // Buffer registers mem[row_cnt] at the end of this cycle.
                    state_r <= CAPTURE;
                end
                CAPTURE: begin
                    row_reg_r    <= rd_data_outbuffer;
                    beat_r       <= '0;
                    m_valid_r    <= 1'b1;
                    m_data_r     <= beat_slice(rd_data_outbuffer, BI_W'(0));
                    m_row_last_r <= (LAST_BEAT == BI_W'(0));
                    m_last_r     <= (LAST_BEAT == BI_W'(0)) && last_row_s;
                    state_r      <= STREAM;
                end
                STREAM: begin
                    if (m_valid_r && strm.m_ready) begin
                        if (beat_r != LAST_BEAT) begin
                            beat_r       <= beat_nxt_s;
                            m_data_r     <= beat_slice(row_reg_r, beat_nxt_s);
                            m_row_last_r <= (beat_nxt_s == LAST_BEAT);
                            m_last_r     <= (beat_nxt_s == LAST_BEAT) && last_row_s;
                        end else begin
                            m_valid_r    <= 1'b0;
                            m_data_r     <= '0;
                            m_row_last_r <= 1'b0;
                            m_last_r     <= 1'b0;
                            if (last_row_s) begin
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state_r <= IDLE;
                            end else begin
                                row_cnt_r <= row_cnt_r + ADDR_ONE;
                                rd_addr_r <= row_cnt_r + ADDR_ONE;
                                state_r   <= ISSUE;
                            end
                        end
                    end else begin
                        state_r <= STREAM;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    m_valid_r    <= 1'b0;
                    m_data_r     <= '0;
                    m_row_last_r <= 1'b0;
                    m_last_r     <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign rd_addr_outbuffer = rd_addr_r;
    assign strm.m_data       = m_data_r;
    assign strm.m_valid      = m_valid_r;
    assign strm.m_row_last   = m_row_last_r;
    assign strm.m_last       = m_last_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign error             = error_r;

endmodule

// File: doc/systolic_out_reader.md
# systolic_out_reader

Drains finished result tiles from the systolic output buffer. The output buffer is the 1024-bit-wide, registered-read memory that `systolic_top` fills when `last_tile` is set. On `start`, the block reads rows 0..`num_rows`-1 through the buffer's read-address port. It splits each row into `BEAT_WIDTH` beats and sends them over a valid/ready stream toward the post-processing/requantization stage. Backpressure is honoured, and data is held stable while it is stalled.

## Interface
Parameters:
- `DATAWIDTH_output`, 32: width of one accumulator word.
- `N_SIZE`, 32: words per buffer row (array width).
- `ADDR_WIDTH`, 10: buffer address width.
- `DEPTH`, 543: number of buffer rows; the highest legal `num_rows`.
- `BEAT_WIDTH`, 256: stream beat width. It must divide `N_SIZE*DATAWIDTH_output`.
- Derived: `ROW_WIDTH` = `N_SIZE*DATAWIDTH_output` (1024); `BEATS` = `ROW_WIDTH/BEAT_WIDTH` (4).

Ports:
- `clk`, in, 1: the single clock. All logic is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: one-cycle request to begin draining. Sampled only in IDLE.
- `num_rows`, in, `ADDR_WIDTH`: number of rows to drain. Sampled with `start`.
- `rd_addr_outbuffer`, out, `ADDR_WIDTH`: registered read address to the output buffer.
- `rd_data_outbuffer`, in, `ROW_WIDTH`: buffer read data. Valid one cycle after an address is presented.
- `m_data`, out, `BEAT_WIDTH`: stream data.
- `m_valid`, out, 1: stream valid.
- `m_ready`, in, 1: stream ready from the consumer.
- `m_row_last`, out, 1: marks the final beat of a row.
- `m_last`, out, 1: marks the final beat of the whole drain.
- `busy`, out, 1: a drain is in progress.
- `done`, out, 1: one-cycle pulse after the final handshake.
- `error`, out, 1: one-cycle pulse when `start` arrives with an illegal `num_rows`.

## Operation
- States are IDLE, ISSUE, CAPTURE and STREAM. Registers are `row_cnt`, `rows_q`, `beat` (`$clog2(BEATS)` bits) and `row_reg` (`ROW_WIDTH` bits).
- **IDLE**:
  - `busy`=0 and `m_valid`=0.
  - On `start` with 1 ≤ `num_rows` ≤ `DEPTH`:
    - latch `rows_q` ← `num_rows`;
    - set `row_cnt` ← 0;
    - register `rd_addr_outbuffer` ← 0;
    - go to ISSUE.
  - On `start` with `num_rows`=0 or `num_rows` > `DEPTH`: pulse `error` next cycle and stay in IDLE.
- **ISSUE**:
  - `rd_addr_outbuffer` = `row_cnt` and is stable for this cycle.
  - The buffer registers `mem[row_cnt]` at the end of this cycle.
  - Next state is CAPTURE.
- **CAPTURE**:
  - `rd_data_outbuffer` is valid.
  - At the end of this cycle: `row_reg` ← `rd_data_outbuffer` and `beat` ← 0.
  - Next state is STREAM.
- **STREAM**:
  - Outputs:
    - `m_valid`=1;
    - `m_data` = `row_reg[beat*BEAT_WIDTH +: BEAT_WIDTH]` (beat 0 is the LSBs, i.e. columns 0..7);
    - `m_row_last` = (`beat`==`BEATS`-1);
    - `m_last` = `m_row_last` && (`row_cnt`==`rows_q`-1).
  - A handshake is `m_valid` && `m_ready`. On each handshake:
    - if not the last beat: `beat`++;
    - on the last beat, not the last row: `row_cnt`++, `rd_addr_outbuffer` ← `row_cnt`+1, go to ISSUE;
    - on the last beat of the last row: go to IDLE and pulse `done` in the next cycle.
  - With `m_valid`=1 and `m_ready`=0: `m_data`, `m_row_last`, `m_last` and state are all held. `m_valid` never drops before its handshake.
- `start` is ignored whenever the state is not IDLE. `num_rows` changes after the latch cycle have no effect.
- `busy`=1 in ISSUE, CAPTURE and STREAM.
- `rd_addr_outbuffer` holds its last value in IDLE.
- Stream outputs (`m_data`, `m_row_last`, `m_last`) are 0 whenever `m_valid`=0.

## Timing
- Reset (`rst`=1 at a rising edge):
  - state becomes IDLE;
  - `rd_addr_outbuffer`, `m_data`, `m_valid`, `m_row_last`, `m_last`, `busy`, `done`, `error` are all 0;
  - `row_cnt`, `beat` and `row_reg` are cleared.
- Reset mid-drain aborts immediately. There is no `done`. The next `start` after reset behaves normally.
- With `start` at cycle T: ISSUE at T+1, CAPTURE at T+2, first `m_valid` at T+3.
- With `m_ready` held at 1, each row takes 2 + `BEATS` = 6 cycles. For R rows, the final handshake is at T+6R and `done` is at T+6R+1.
- If `rst` and `start` are high in the same cycle, reset wins.
- `done` and `error` are never high in the same cycle.

## Test plan
- Preload rows 0..3, word (r,c) = r*256+c. Pulse `start` with `num_rows`=4 and hold `m_ready`=1. Require:
  - 16 beats total;
  - beat 1 of row 2 carries words 0x208..0x20F;
  - `m_row_last` on every 4th beat and `m_last` only on beat 16;
  - `done` exactly at T+25.
- Same data with `m_ready` toggling 1,0,0,1… Require `m_data` stable on every stalled cycle, the identical 16-beat sequence, and no duplicated or dropped beats.
- Pulse `start` with `num_rows`=0, then with 544. Require `error` pulsed once each, `busy` staying 0, and no address change.
- Pulse `start` again during an active drain with `num_rows`=2. Require it ignored: the original count completes and only one `done` is seen.
- Assert `rst` in STREAM during row 1 of 4. Require all outputs 0 next cycle and no `done`. Then run `start` with `num_rows`=1: exactly 4 beats from row 0.
- Drain with `num_rows`=`DEPTH`=543. Require the final `rd_addr_outbuffer`=542, `m_last` on beat 2172, and a single `done`.
